// File: rtl/bus85_ctrl.sv
// core85 bus controller: address latch, strobe decode, READY wait-state insertion, HOLD/HLDA DMA arbiter.
// Latency: strobes/ready combinational from pins; lat_addr one edge after ALE; hold/dma_gnt registered, one edge per arbiter step.
// Backpressure: core is stalled via ready=0 for the programmed Tw count; DMA requests are held off during release and the gap window.
module bus85_ctrl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 16,
  parameter int MEMWAIT  = 1,
  parameter int IOWAIT   = 2,
  parameter logic [ADDRSIZE-DATASIZE-1:0] SLOWBASE = 8'hE0,
  parameter int HOLDGAP  = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_,
  input  logic                         i_ale,
  input  logic                         i_iom_,
  input  logic                         i_rd_,
  input  logic                         i_wr_,
  input  logic [ADDRSIZE-DATASIZE-1:0] i_addr,
  input  logic [DATASIZE-1:0]          i_addrdata,
  input  logic                         i_hlda,
  output logic                         o_ready,
  output logic                         o_hold,
  output logic [ADDRSIZE-1:0]          o_lat_addr,
  output logic                         o_mem_rd,
  output logic                         o_mem_wr,
  output logic                         o_io_rd,
  output logic                         o_io_wr,
  input  logic                         i_dma_req,
  output logic                         o_dma_gnt
);

  localparam int WMAX = (IOWAIT > MEMWAIT) ? IOWAIT : MEMWAIT;
  localparam int WCW  = (WMAX < 2) ? 1 : $clog2(WMAX + 1);
  localparam int GCW  = (HOLDGAP < 2) ? 1 : $clog2(HOLDGAP + 1);

  localparam logic [WCW-1:0] W_IO   = WCW'(IOWAIT);
  localparam logic [WCW-1:0] W_MEM  = WCW'(MEMWAIT);
  localparam logic [WCW-1:0] W_ONE  = WCW'(1);
  localparam logic [GCW-1:0] G_LOAD = GCW'(HOLDGAP);
  localparam logic [GCW-1:0] G_ONE  = GCW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HREQ  = 3'd1,
    S_GRANT = 3'd2,
    S_REL   = 3'd3,
    S_GAP   = 3'd4
  } arb_t;

  logic [ADDRSIZE-1:0] r_lat_addr;
  logic                r_io_flag;
  logic [WCW-1:0]      r_wcnt;
  arb_t                r_state;
  logic [GCW-1:0]      r_gcnt;
  logic                r_hold;
  logic                r_dma_gnt;

  logic w_cyc_act;
  logic w_wait;

  // A bus cycle is in its data phase whenever either strobe pin is low;
  // it is stretched while wait states remain.
  assign w_cyc_act = ~i_rd_ | ~i_wr_;
  assign w_wait    = w_cyc_act & (r_wcnt != '0);

  assign o_ready    = ~w_wait;
  assign o_hold     = r_hold;
  assign o_dma_gnt  = r_dma_gnt;
  assign o_lat_addr = r_lat_addr;

  // Decoded strobes; the DMA master owns the fabric while granted, so the core's strobes are masked.
  assign o_mem_rd = ~i_rd_ & ~r_io_flag & ~r_dma_gnt;
  assign o_mem_wr = ~i_wr_ & ~r_io_flag & ~r_dma_gnt;
  assign o_io_rd  = ~i_rd_ &  r_io_flag & ~r_dma_gnt;
  assign o_io_wr  = ~i_wr_ &  r_io_flag & ~r_dma_gnt;

  // Address latch and wait-state counter; a new ALE reloads even if an aborted cycle left waits pending.
  always_ff @(posedge i_clk) begin
    if (!i_rst_) begin
      r_lat_addr <= '0;
      r_io_flag  <= 1'b0;
      r_wcnt     <= '0;
    end else if (i_ale) begin
      r_lat_addr <= {i_addr, i_addrdata};
      r_io_flag  <= i_iom_;
      if (i_iom_)
        r_wcnt <= W_IO;
      else if (i_addr >= SLOWBASE)
        r_wcnt <= W_MEM;
      else
        r_wcnt <= '0;
    end else if (w_wait) begin
      r_wcnt <= r_wcnt - W_ONE;
    end
  end

  // HOLD/HLDA arbiter with a guaranteed gap handed back to the core between grants.
  always_ff @(posedge i_clk) begin
    if (!i_rst_) begin
      r_state   <= S_IDLE;
      r_gcnt    <= '0;
      r_hold    <= 1'b0;
      r_dma_gnt <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_dma_req && (r_gcnt == '0)) begin
            r_hold  <= 1'b1;
            r_state <= S_HREQ;
          end
        end
        S_HREQ: begin
          // An acknowledge that arrives is honoured first; a withdrawn request then releases from GRANT.
          if (i_hlda) begin
            r_dma_gnt <= 1'b1;
            r_state   <= S_GRANT;
          end else if (!i_dma_req) begin
            r_hold  <= 1'b0;
            r_state <= S_REL;
          end
        end
        S_GRANT: begin
          if (!i_dma_req) begin
            r_hold    <= 1'b0;
            r_dma_gnt <= 1'b0;
            r_state   <= S_REL;
          end
        end
        S_REL: begin
          if (!i_hlda) begin
            r_gcnt  <= G_LOAD;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gcnt <= G_ONE) begin
            r_gcnt  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt - G_ONE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_gcnt    <= '0;
          r_hold    <= 1'b0;
          r_dma_gnt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus85_ctrl.sv
// Testbench for bus85_ctrl: directed bus/DMA scenarios followed by randomized traffic.
// Every cycle all outputs are compared against a behavioural model held in the bench.
// Inputs change 1 time unit after posedge; outputs are sampled mid-cycle and just after each edge.
module tb_bus85_ctrl;

  localparam int  MEMWAIT  = 1;
  localparam int  IOWAIT   = 2;
  localparam int  SLOWBASE = 8'hE0;
  localparam int  HOLDGAP  = 4;

  logic        clk;
  logic        rst_;
  logic        ale, iom_, rd_, wr_, hlda, dma_req;
  logic [7:0]  addr, ad;
  logic        ready, hold, mem_rd, mem_wr, io_rd, io_wr, dma_gnt;
  logic [15:0] lat_addr;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: bus side
  logic [15:0] m_addr;
  bit          m_io;
  int          m_waits;
  // Behavioural model: arbiter side
  bit          m_hold, m_gnt, m_releasing;
  int          m_block;

  bus85_ctrl #(
    .DATASIZE(8), .ADDRSIZE(16), .MEMWAIT(MEMWAIT), .IOWAIT(IOWAIT),
    .SLOWBASE(8'hE0), .HOLDGAP(HOLDGAP)
  ) dut (
    .i_clk(clk), .i_rst_(rst_), .i_ale(ale), .i_iom_(iom_), .i_rd_(rd_), .i_wr_(wr_),
    .i_addr(addr), .i_addrdata(ad), .i_hlda(hlda),
    .o_ready(ready), .o_hold(hold), .o_lat_addr(lat_addr),
    .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_io_rd(io_rd), .o_io_wr(io_wr),
    .i_dma_req(dma_req), .o_dma_gnt(dma_gnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_addr = 16'h0; m_io = 0; m_waits = 0;
    m_hold = 0; m_gnt = 0; m_releasing = 0; m_block = 0;
  endfunction

  // Advance the model by one clock edge using the pin values present at that edge.
  function automatic void m_edge();
    bit strobe;
    if (!rst_) begin
      m_reset();
      return;
    end
    strobe = !rd_ || !wr_;
    if (ale) begin
      m_addr = {addr, ad};
      m_io   = iom_;
      if (iom_)                 m_waits = IOWAIT;
      else if (addr >= SLOWBASE) m_waits = MEMWAIT;
      else                      m_waits = 0;
    end else if (strobe && m_waits > 0) begin
      m_waits = m_waits - 1;
    end
    if (m_block > 0) begin
      m_block = m_block - 1;
    end else if (m_releasing) begin
      if (!hlda) begin
        m_releasing = 0;
        m_block = HOLDGAP;
      end
    end else if (m_gnt) begin
      if (!dma_req) begin
        m_hold = 0; m_gnt = 0; m_releasing = 1;
      end
    end else if (m_hold) begin
      if (hlda) m_gnt = 1;
      else if (!dma_req) begin
        m_hold = 0; m_releasing = 1;
      end
    end else if (dma_req) begin
      m_hold = 1;
    end
  endfunction

  task automatic check_all(input string ph);
    bit strobe;
    strobe = !rd_ || !wr_;
    chk({ph, "_ready"},  32'(ready),    32'(!(strobe && m_waits != 0)));
    chk({ph, "_hold"},   32'(hold),     32'(m_hold));
    chk({ph, "_gnt"},    32'(dma_gnt),  32'(m_gnt));
    chk({ph, "_lat"},    32'(lat_addr), 32'(m_addr));
    chk({ph, "_memrd"},  32'(mem_rd),   32'(!rd_ && !m_io && !m_gnt));
    chk({ph, "_memwr"},  32'(mem_wr),   32'(!wr_ && !m_io && !m_gnt));
    chk({ph, "_iord"},   32'(io_rd),    32'(!rd_ && m_io && !m_gnt));
    chk({ph, "_iowr"},   32'(io_wr),    32'(!wr_ && m_io && !m_gnt));
  endtask

  // One clock: check with current inputs, take the edge, check post-edge state.
  task automatic cyc();
    #2;
    check_all("pre");
    @(posedge clk);
    m_edge();
    #1;
    check_all("post");
  endtask

  task automatic bus_idle();
    ale = 0; rd_ = 1; wr_ = 1;
  endtask

  initial begin
    int k;
    rst_ = 0; ale = 0; iom_ = 0; rd_ = 1; wr_ = 1; hlda = 0; dma_req = 0;
    addr = 8'h00; ad = 8'h00;
    @(posedge clk);
    m_reset();
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_hold",  32'(hold), 32'd0);
    chk("rst_gnt",   32'(dma_gnt), 32'd0);
    chk("rst_lat",   32'(lat_addr), 32'h0);
    rst_ = 1;
    cyc();

    // Zero-wait memory read
    ale = 1; iom_ = 0; addr = 8'h20; ad = 8'h00;
    cyc();
    ale = 0; rd_ = 0;
    #1;
    chk("zw_lat",   32'(lat_addr), 32'h2000);
    chk("zw_memrd", 32'(mem_rd), 32'd1);
    chk("zw_rdy0",  32'(ready), 32'd1);
    cyc();
    chk("zw_rdy1",  32'(ready), 32'd1);
    cyc();
    bus_idle(); cyc();

    // Slow memory write: one Tw
    ale = 1; iom_ = 0; addr = 8'hF0; ad = 8'h12;
    cyc();
    ale = 0; wr_ = 0;
    #1;
    chk("sw_memwr", 32'(mem_wr), 32'd1);
    chk("sw_rdy0",  32'(ready), 32'd0);
    cyc();
    chk("sw_rdy1",  32'(ready), 32'd1);
    bus_idle(); cyc();

    // I/O read: two Tw
    ale = 1; iom_ = 1; addr = 8'h00; ad = 8'h40;
    cyc();
    ale = 0; rd_ = 0;
    #1;
    chk("io_iord",  32'(io_rd), 32'd1);
    chk("io_memrd", 32'(mem_rd), 32'd0);
    chk("io_rdy0",  32'(ready), 32'd0);
    cyc();
    chk("io_rdy1",  32'(ready), 32'd0);
    cyc();
    chk("io_rdy2",  32'(ready), 32'd1);
    bus_idle(); cyc();

    // DMA grant
    dma_req = 1;
    cyc();
    chk("dma_hold", 32'(hold), 32'd1);
    cyc(); cyc(); cyc();
    chk("dma_nognt", 32'(dma_gnt), 32'd0);
    hlda = 1;
    cyc();
    chk("dma_gnt", 32'(dma_gnt), 32'd1);
    rd_ = 0;
    #1;
    chk("dma_mask", 32'(io_rd), 32'd0);
    cyc();
    rd_ = 1; dma_req = 0;
    cyc();
    chk("dma_rel_hold", 32'(hold), 32'd0);
    chk("dma_rel_gnt",  32'(dma_gnt), 32'd0);

    // Back-to-back request: held off through release and gap
    dma_req = 1;
    cyc(); cyc();
    hlda = 0;
    cyc();
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (hold) begin
        k = i;
        break;
      end
    end
    chk("b2b_gap_ok", 32'(k >= HOLDGAP && k <= HOLDGAP + 2), 32'd1);
    hlda = 1;
    cyc();
    chk("b2b_gnt", 32'(dma_gnt), 32'd1);

    // Reset while granted with two waits pending
    ale = 1; iom_ = 1; addr = 8'h12; ad = 8'h55;
    cyc();
    ale = 0; rd_ = 0;
    #1;
    chk("rg_rdy0", 32'(ready), 32'd0);
    rst_ = 0;
    cyc();
    chk("rg_hold",  32'(hold), 32'd0);
    chk("rg_gnt",   32'(dma_gnt), 32'd0);
    chk("rg_ready", 32'(ready), 32'd1);
    chk("rg_lat",   32'(lat_addr), 32'h0);
    rst_ = 1; rd_ = 1; hlda = 0;
    cyc();
    chk("rg_idle_req", 32'(hold), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_ = ($urandom_range(0, 199) != 0);
      ale  = ($urandom_range(0, 4) == 0);
      iom_ = ($urandom_range(0, 2) == 0);
      addr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'hD8, 8'hFF)) : 8'($urandom);
      ad   = 8'($urandom);
      case ($urandom_range(0, 2))
        0: begin rd_ = 0; wr_ = 1; end
        1: begin rd_ = 1; wr_ = 0; end
        default: begin rd_ = 1; wr_ = 1; end
      endcase
      if ($urandom_range(0, 9) == 0) dma_req = ~dma_req;
      if (m_hold) begin
        if ($urandom_range(0, 2) == 0) hlda = 1;
      end else begin
        if ($urandom_range(0, 2) == 0) hlda = 0;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
